// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
//   Instruction fetch stage with a small prefetch queue. Up to MAX_OUTSTANDING
//   requests may be in flight to instruction memory. Returned instructions are
//   buffered in a FIFO_DEPTH-entry queue and presented to ID as {inst, pc}.
//   A taken branch from ID flushes the queue, restarts fetch at the target and
//   arms a discard counter that swallows the stale in-flight responses.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   id_allow_in         ID can accept an instruction this cycle
//   id_valid, br_bus    branch redirect {br_en, br_target}; used only if id_valid
//   if_to_id_valid/bus  queue head {inst, pc} to ID (bus is 0 when empty)
//   Inst_Req_Valid/Ready, PC          request channel to instruction memory
//   Inst_Valid/Ready, Instruction     in-order response channel
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BR_BUS_WD       = 33,
  parameter int          IF_TO_ID_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_allow_in,
  input  logic                       id_valid,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       if_to_id_valid,
  output logic [IF_TO_ID_BUS_WD-1:0] if_to_id_bus,
  output logic                       Inst_Req_Valid,
  input  logic                       Inst_Req_Ready,
  output logic [31:0]                PC,
  input  logic                       Inst_Valid,
  output logic                       Inst_Ready,
  input  logic [31:0]                Instruction
);

  localparam int QW = $clog2(FIFO_DEPTH);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } q_entry_t;

  // ---------------------------------------------------------------- state
  logic [31:0]   fetch_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] discard_cnt;

  q_entry_t      q_mem [FIFO_DEPTH];
  logic [QW-1:0] q_wr, q_rd;
  logic [QW:0]   q_cnt;

  logic [31:0]   tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr, tag_rd;

  // ---------------------------------------------------------------- control
  logic          redirect;
  logic [31:0]   br_target;
  logic          req_fire, rsp_fire, pop, push;
  logic [QW+1:0] credit_sum;
  q_entry_t      head;

  assign redirect   = id_valid & br_bus[BR_BUS_WD-1];
  assign br_target  = br_bus[31:0];

  // Queue entries plus in-flight requests never exceed the queue size, so any
  // accepted response always has a slot waiting for it.
  assign credit_sum = {1'b0, q_cnt} + (QW+2)'(out_cnt);

  assign Inst_Req_Valid = reset & ~redirect
                        & (out_cnt < CW'(MAX_OUTSTANDING))
                        & (credit_sum < (QW+2)'(FIFO_DEPTH));
  assign PC         = fetch_pc;
  assign Inst_Ready = reset;

  assign req_fire = Inst_Req_Valid & Inst_Req_Ready;
  assign rsp_fire = Inst_Valid & Inst_Ready;

  // A response is kept only if it is not stale and no redirect is happening
  // right now (the queue is being flushed this cycle).
  assign push = rsp_fire & (discard_cnt == '0) & ~redirect;

  assign if_to_id_valid = (q_cnt != '0) & ~redirect;
  assign pop            = if_to_id_valid & id_allow_in;

  assign head         = (q_cnt != '0) ? q_mem[q_rd] : '0;
  assign if_to_id_bus = IF_TO_ID_BUS_WD'(head);

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // ---------------------------------------------------------------- fetch pc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= br_target;
    else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
  end

  // ---------------------------------------------------------------- outstanding / discard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Stale responses already counted in discard_cnt are a subset of out_cnt,
  // so on redirect the new stale count is simply everything still in flight
  // after this cycle; this also keeps back-to-back redirects exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      discard_cnt <= '0;
    else if (redirect)
      discard_cnt <= out_cnt - CW'(rsp_fire);
    else if (rsp_fire && discard_cnt != '0)
      discard_cnt <= discard_cnt - CW'(1);
  end

  // ---------------------------------------------------------------- pc tag fifo
  // Holds the address of every in-flight request. Stale responses still pop
  // their tag, so it is never flushed on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (req_fire) tag_wr <= tag_inc(tag_wr);
      if (rsp_fire) tag_rd <= tag_inc(tag_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
  end

  // ---------------------------------------------------------------- prefetch queue
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= '{inst: Instruction, pc: tag_mem[tag_rd]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else if (redirect) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) q_wr <= q_wr + QW'(1);
      if (pop)  q_rd <= q_rd + QW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (QW+1)'(1);
        2'b01:   q_cnt <= q_cnt - (QW+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage (FIFO_DEPTH=4, MAX_OUTSTANDING=2).
// A queue-based memory model answers requests one cycle after acceptance
// (responses can be held back with mem_en). Inputs change 1 time unit after
// the rising edge; outputs are checked 1 unit later.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allow_in, id_valid;
  logic [32:0] br_bus;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        Inst_Req_Valid, Inst_Req_Ready;
  logic [31:0] PC;
  logic        Inst_Valid, Inst_Ready;
  logic [31:0] Instruction;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
    .BR_BUS_WD(33), .IF_TO_ID_BUS_WD(64)
  ) dut (
    .clk(clk), .reset(reset), .id_allow_in(id_allow_in), .id_valid(id_valid),
    .br_bus(br_bus), .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready), .PC(PC),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Instruction(Instruction)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } deliv_t;
  logic [31:0] mem_q [$];
  logic [31:0] rlog  [$];
  deliv_t      dlog  [$];
  bit          mem_en;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_mem();
    Inst_Valid  = mem_en && (mem_q.size() > 0);
    Instruction = (mem_q.size() > 0) ? inst_of(mem_q[0]) : 32'h0;
  endtask

  // Samples handshakes of the current cycle, steps one edge, updates the model.
  task automatic advance();
    bit rf, sf;
    logic [31:0] p;
    deliv_t d;
    rf = Inst_Req_Valid && Inst_Req_Ready;
    sf = Inst_Valid && Inst_Ready;
    p  = PC;
    if (rf) rlog.push_back(p);
    if (if_to_id_valid && id_allow_in) begin
      d.pc = if_to_id_bus[31:0]; d.inst = if_to_id_bus[63:32];
      dlog.push_back(d);
    end
    @(posedge clk); #1;
    if (sf) void'(mem_q.pop_front());
    if (rf) mem_q.push_back(p);
    drive_mem();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin #1; advance(); end
  endtask

  task automatic do_reset();
    reset = 1'b0; id_valid = 1'b0; br_bus = '0; id_allow_in = 1'b1;
    Inst_Req_Ready = 1'b1; mem_en = 1'b1;
    mem_q.delete(); drive_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", 64'(if_to_id_valid), 64'd0);
    check("rst_req_valid", 64'(Inst_Req_Valid), 64'd0);
    check("rst_inst_ready", 64'(Inst_Ready), 64'd0);
    check("rst_bus", if_to_id_bus, 64'd0);
    rlog.delete(); dlog.delete();
    reset = 1'b1;   // released at edge+1; caller settles with its own #1
  endtask

  // Fill / stall / drain table for id_allow_in=0 then 1
  typedef struct {
    bit          allow;
    bit          rv;
    logic [31:0] pc;
    bit          ifv;
    logic [31:0] bpc;
  } vec_t;
  vec_t tbl [11];

  int stale;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0, 1, 32'h00, 0, 32'h00};
    tbl[1]  = '{0, 1, 32'h04, 0, 32'h00};
    tbl[2]  = '{0, 1, 32'h08, 1, 32'h00};
    tbl[3]  = '{0, 1, 32'h0C, 1, 32'h00};
    tbl[4]  = '{0, 0, 32'h10, 1, 32'h00};
    tbl[5]  = '{0, 0, 32'h10, 1, 32'h00};
    tbl[6]  = '{1, 0, 32'h10, 1, 32'h00};
    tbl[7]  = '{1, 1, 32'h10, 1, 32'h04};
    tbl[8]  = '{1, 1, 32'h14, 1, 32'h08};
    tbl[9]  = '{1, 1, 32'h18, 1, 32'h0C};
    tbl[10] = '{1, 1, 32'h1C, 1, 32'h10};

    // ---- steady-state streaming
    do_reset();
    cycles(12);
    check("s1_req_count", 64'(rlog.size()), 64'd12);
    check("s1_deliv_count", 64'(dlog.size()), 64'd10);
    for (int i = 0; i < rlog.size() && i < 12; i++)
      check("s1_req_pc", 64'(rlog[i]), 64'(4 * i));
    for (int i = 0; i < dlog.size() && i < 10; i++) begin
      check("s1_deliv_pc", 64'(dlog[i].pc), 64'(4 * i));
      check("s1_deliv_inst", 64'(dlog[i].inst), 64'(inst_of(32'(4 * i))));
    end

    // ---- queue fill with ID stalled, then drain
    do_reset();
    for (int i = 0; i < 11; i++) begin
      id_allow_in = tbl[i].allow;
      #1;
      check("s2_req_valid", 64'(Inst_Req_Valid), 64'(tbl[i].rv));
      check("s2_pc", 64'(PC), 64'(tbl[i].pc));
      check("s2_if_valid", 64'(if_to_id_valid), 64'(tbl[i].ifv));
      check("s2_bus", if_to_id_bus, tbl[i].ifv ? {inst_of(tbl[i].bpc), tbl[i].bpc} : 64'd0);
      advance();
    end
    check("s2_req_count", 64'(rlog.size()), 64'd8);

    // ---- redirect with 0x8/0xC in flight
    do_reset();
    cycles(3);
    mem_en = 1'b0; drive_mem();
    cycles(1);
    id_valid = 1'b1; br_bus = {1'b1, 32'h100};
    #1;
    check("s3_redir_req_valid", 64'(Inst_Req_Valid), 64'd0);
    check("s3_redir_if_valid", 64'(if_to_id_valid), 64'd0);
    advance();
    id_valid = 1'b0; br_bus = '0; mem_en = 1'b1; drive_mem();
    cycles(6);
    check("s3_deliv_count", 64'(dlog.size()), 64'd5);
    if (dlog.size() >= 4) begin
      check("s3_first_target_pc", 64'(dlog[2].pc), 64'h100);
      check("s3_first_target_inst", 64'(dlog[2].inst), 64'(inst_of(32'h100)));
      check("s3_second_target_pc", 64'(dlog[3].pc), 64'h104);
    end
    stale = 0;
    foreach (dlog[i]) if (dlog[i].pc == 32'h8 || dlog[i].pc == 32'hC) stale++;
    check("s3_stale_delivered", 64'(stale), 64'd0);

    // ---- response arriving in the redirect cycle
    do_reset();
    cycles(3);
    mem_en = 1'b0; drive_mem();
    cycles(1);
    mem_en = 1'b1; drive_mem();
    id_valid = 1'b1; br_bus = {1'b1, 32'h200};
    #1;
    check("s4_rsp_offered", 64'(Inst_Valid && Inst_Ready), 64'd1);
    check("s4_redir_req_valid", 64'(Inst_Req_Valid), 64'd0);
    advance();
    id_valid = 1'b0; br_bus = '0;
    #1;
    check("s4_req_valid_after", 64'(Inst_Req_Valid), 64'd1);
    check("s4_pc_after", 64'(PC), 64'h200);
    advance();
    cycles(3);
    check("s4_deliv_count", 64'(dlog.size()), 64'd4);
    if (dlog.size() >= 4) begin
      check("s4_target_pc", 64'(dlog[2].pc), 64'h200);
      check("s4_next_pc", 64'(dlog[3].pc), 64'h204);
    end
    stale = 0;
    foreach (dlog[i]) if (dlog[i].pc == 32'h8 || dlog[i].pc == 32'hC) stale++;
    check("s4_stale_delivered", 64'(stale), 64'd0);

    // ---- memory request backpressure for 5 cycles
    do_reset();
    cycles(6);
    Inst_Req_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s5_req_valid_held", 64'(Inst_Req_Valid), 64'd1);
      check("s5_pc_held", 64'(PC), 64'h18);
      advance();
    end
    Inst_Req_Ready = 1'b1;
    cycles(6);
    check("s5_deliv_count", 64'(dlog.size()), 64'd10);
    foreach (dlog[i]) check("s5_deliv_pc", 64'(dlog[i].pc), 64'(4 * i));

    // ---- asynchronous reset between clock edges
    do_reset();
    cycles(5);
    #1;
    check("s6_pre_if_valid", 64'(if_to_id_valid), 64'd1);
    reset = 1'b0;
    mem_q.delete(); drive_mem();
    #1;
    check("s6_async_if_valid", 64'(if_to_id_valid), 64'd0);
    check("s6_async_req_valid", 64'(Inst_Req_Valid), 64'd0);
    check("s6_async_inst_ready", 64'(Inst_Ready), 64'd0);
    check("s6_async_bus", if_to_id_bus, 64'd0);
    @(posedge clk); #1;
    rlog.delete(); dlog.delete();
    reset = 1'b1;
    #1;
    check("s6_restart_req_valid", 64'(Inst_Req_Valid), 64'd1);
    check("s6_restart_pc", 64'(PC), 64'h0);
    advance();
    cycles(3);
    check("s6_restart_deliv_count", 64'(dlog.size()), 64'd2);
    if (dlog.size() >= 2) begin
      check("s6_restart_first_pc", 64'(dlog[0].pc), 64'h0);
      check("s6_restart_second_pc", 64'(dlog[1].pc), 64'h4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
